// File: rtl/alu_arbiter_seq.sv
// Round-robin controller sharing one registered add/subtract datapath between two requesters.
// MUL is sequenced as repeated additions; results return on one tagged response channel.
module alu_arbiter_seq #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned OPW   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_err,
   output logic [OPW-1:0]   alu_opcode,
   output logic [WIDTH-1:0] alu_ain,
   output logic [WIDTH-1:0] alu_bin,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_EXEC      = 3'd1;
   localparam logic [2:0] S_WAIT      = 3'd2;
   localparam logic [2:0] S_MUL_ISSUE = 3'd3;
   localparam logic [2:0] S_MUL_WAIT  = 3'd4;
   localparam logic [2:0] S_RESP      = 3'd5;

   localparam logic [OPW-1:0] OP_NOP = OPW'(0);
   localparam logic [OPW-1:0] OP_ADD = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB = OPW'(2);
   localparam logic [OPW-1:0] OP_MUL = OPW'(3);

   logic [2:0]       state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             last_grant_q, last_grant_d;

   logic             grant_id;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         acc_q        <= '0;
         count_q      <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         acc_q        <= acc_d;
         count_q      <= count_d;
         result_q     <= result_d;
         err_q        <= err_d;
         last_grant_q <= last_grant_d;
      end
   end

   // With both valid the requester not served last wins; otherwise the single valid one.
   always_comb begin
      grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      sel_op   = grant_id ? req1_opcode : req0_opcode;
      sel_a    = grant_id ? req1_a      : req0_a;
      sel_b    = grant_id ? req1_b      : req0_b;
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      acc_d        = acc_q;
      count_d      = count_q;
      result_d     = result_q;
      err_d        = err_q;
      last_grant_d = last_grant_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      alu_opcode   = OP_NOP;
      alu_ain      = '0;
      alu_bin      = '0;

      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               op_d       = sel_op;
               a_d        = sel_a;
               b_d        = sel_b;
               id_d       = grant_id;
               err_d      = 1'b0;
               if (sel_op == OP_ADD || sel_op == OP_SUB) begin
                  state_d = S_EXEC;
               end else if (sel_op == OP_MUL && sel_b != '0) begin
                  acc_d   = '0;
                  count_d = sel_b;
                  state_d = S_MUL_ISSUE;
               end else begin
                  result_d = '0;
                  err_d    = (sel_op != OP_MUL);
                  state_d  = S_RESP;
               end
            end
         end
         S_EXEC: begin
            alu_opcode = op_q;
            alu_ain    = a_q;
            alu_bin    = b_q;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            result_d = alu_out;
            state_d  = S_RESP;
         end
         S_MUL_ISSUE: begin
            alu_opcode = OP_ADD;
            alu_ain    = acc_q;
            alu_bin    = a_q;
            state_d    = S_MUL_WAIT;
         end
         S_MUL_WAIT: begin
            acc_d   = alu_out;
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
               result_d = alu_out;
               state_d  = S_RESP;
            end else begin
               state_d = S_MUL_ISSUE;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               last_grant_d = id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resp_valid = (state_q == S_RESP);
      resp_id    = id_q;
      resp_data  = result_q;
      resp_err   = err_q;
      busy       = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Randomized self-checking bench for alu_arbiter_seq with a behavioural datapath
// and a reference model of arbitration order, results, latency and datapath pulses.
module tb_alu_arbiter_seq;

   logic       clock;
   logic       reset;
   logic       req0_valid, req0_ready;
   logic [3:0] req0_opcode, req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [3:0] req1_opcode, req1_a, req1_b;
   logic       resp_valid, resp_ready, resp_id, resp_err;
   logic [3:0] resp_data;
   logic [3:0] alu_opcode, alu_ain, alu_bin, alu_out;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Pending request per requester and the model's view of who was served last.
   logic       pv  [2];
   logic [3:0] opv [2];
   logic [3:0] av  [2];
   logic [3:0] bv  [2];
   int         lg_m;

   alu_arbiter_seq #(.WIDTH(4), .OPW(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_opcode(req0_opcode),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_opcode(req1_opcode),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .alu_opcode (alu_opcode),
      .alu_ain    (alu_ain),
      .alu_bin    (alu_bin),
      .alu_out    (alu_out),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural datapath: registered result, 0001 add, 0010 subtract, otherwise hold.
   always @(posedge clock or posedge reset) begin
      if (reset)                 alu_out <= 4'd0;
      else if (alu_opcode == 1)  alu_out <= alu_ain + alu_bin;
      else if (alu_opcode == 2)  alu_out <= alu_ain - alu_bin;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester rule: payload held while valid is high and ready is low.
   logic        pr_v0, pr_r0, pr_v1, pr_r1;
   logic [11:0] pr_p0, pr_p1;
   always @(posedge clock) begin
      if (!reset) begin
         if (pr_v0 && !pr_r0 && req0_valid) check("stable0", {req0_opcode, req0_a, req0_b}, pr_p0);
         if (pr_v1 && !pr_r1 && req1_valid) check("stable1", {req1_opcode, req1_a, req1_b}, pr_p1);
      end
      pr_v0 = req0_valid; pr_r0 = req0_ready; pr_p0 = {req0_opcode, req0_a, req0_b};
      pr_v1 = req1_valid; pr_r1 = req1_ready; pr_p1 = {req1_opcode, req1_a, req1_b};
   end

   // Reference: {err, data} from the arithmetic rules, modulo 16.
   function automatic logic [4:0] ref_result(input logic [3:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
      int r;
      case (op)
         4'd1:    r = (int'(a) + int'(b)) % 16;
         4'd2:    r = (int'(a) + 16 - int'(b)) % 16;
         4'd3:    r = (int'(a) * int'(b)) % 16;
         default: return 5'b1_0000;
      endcase
      return {1'b0, 4'(r)};
   endfunction

   // Edges after the accept edge until resp_valid; 0 means it responds on the accept edge.
   function automatic int ref_latency(input logic [3:0] op, input logic [3:0] b);
      if (op == 4'd1 || op == 4'd2) return 2;
      if (op == 4'd3)               return 2 * int'(b);
      return 0;
   endfunction

   function automatic int ref_pulses(input logic [3:0] op, input logic [3:0] b);
      if (op == 4'd1 || op == 4'd2) return 1;
      if (op == 4'd3)               return int'(b);
      return 0;
   endfunction

   task automatic apply();
      req0_valid = pv[0]; req0_opcode = opv[0]; req0_a = av[0]; req0_b = bv[0];
      req1_valid = pv[1]; req1_opcode = opv[1]; req1_a = av[1]; req1_b = bv[1];
   endtask

   task automatic set_req(input int idx, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b);
      pv[idx] = 1'b1; opv[idx] = op; av[idx] = a; bv[idx] = b;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      pv[0] = 1'b0; pv[1] = 1'b0;
      apply();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      lg_m  = 1;
   endtask

   // Serve every pending request; called at a negedge, returns at a negedge in IDLE.
   task automatic serve_all(input int hold);
      int         w, k, pulses, lat_e, np_e;
      logic [4:0] exp;
      logic [3:0] wop, wa, wb;
      while (pv[0] || pv[1]) begin
         resp_ready = (hold == 0);
         apply();
         #1;
         w   = (pv[0] && pv[1]) ? (1 - lg_m) : (pv[1] ? 1 : 0);
         wop = opv[w]; wa = av[w]; wb = bv[w];
         exp   = ref_result(wop, wa, wb);
         lat_e = ref_latency(wop, wb);
         np_e  = ref_pulses(wop, wb);
         check("ready_winner", (w == 0) ? req0_ready : req1_ready, 1);
         check("ready_loser",  (w == 0) ? req1_ready : req0_ready, 0);
         @(posedge clock);
         @(negedge clock);
         pv[w] = 1'b0;
         k = 0; pulses = 0;
         while (1) begin
            if (alu_opcode != 4'd0) begin
               if (wop == 4'd3) begin
                  check("mul_op",  alu_opcode, 1);
                  check("mul_ain", alu_ain, (pulses * int'(wa)) % 16);
                  check("mul_bin", alu_bin, wa);
               end else begin
                  check("exec_op",  alu_opcode, wop);
                  check("exec_ain", alu_ain, wa);
                  check("exec_bin", alu_bin, wb);
               end
               pulses++;
            end
            apply();
            if (resp_valid) break;
            check("busy_run", busy, 1);
            check("no_ready_run", {req0_ready, req1_ready}, 0);
            if (k >= 40) begin
               check("resp_timeout", resp_valid, 1);
               break;
            end
            @(negedge clock);
            k++;
         end
         check("latency",   k, lat_e);
         check("pulses",    pulses, np_e);
         check("resp_id",   resp_id, w);
         check("resp_data", resp_data, exp[3:0]);
         check("resp_err",  resp_err, exp[4]);
         for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_data",  {resp_id, resp_err, resp_data}, {w[0], exp[4], exp[3:0]});
            check("hold_busy",  busy, 1);
            check("hold_ready", {req0_ready, req1_ready}, 0);
         end
         resp_ready = 1'b1;
         @(negedge clock);
         check("idle_valid", resp_valid, 0);
         check("idle_busy",  busy, 0);
         lg_m = w;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses, k;
      reset = 1'b1; resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin pv[i] = 1'b0; opv[i] = '0; av[i] = '0; bv[i] = '0; end
      apply();
      lg_m = 1;
      repeat (2) @(negedge clock);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy",       busy, 0);
      check("rst_alu_op",     alu_opcode, 0);
      check("rst_resp_data",  resp_data, 0);
      check("rst_ready",      {req0_ready, req1_ready}, 0);
      reset = 1'b0;

      set_req(0, 4'd1, 4'd3, 4'd4);
      serve_all(0);

      do_reset();
      set_req(0, 4'd2, 4'd2, 4'd5);
      set_req(1, 4'd1, 4'd9, 4'd9);
      serve_all(0);
      set_req(0, 4'd2, 4'd2, 4'd5);
      set_req(1, 4'd1, 4'd9, 4'd9);
      serve_all(0);

      set_req(1, 4'd3, 4'd3, 4'd5);  serve_all(0);
      set_req(1, 4'd3, 4'd7, 4'd3);  serve_all(0);
      set_req(1, 4'd3, 4'd9, 4'd0);  serve_all(0);
      set_req(0, 4'd7, 4'd5, 4'd6);  serve_all(0);
      set_req(0, 4'd15, 4'd15, 4'd15); serve_all(0);

      set_req(0, 4'd1, 4'd1, 4'd2);
      set_req(1, 4'd2, 4'd8, 4'd3);
      serve_all(5);

      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < 2; r++) begin
            int sel;
            sel = int'($urandom % 8);
            if ($urandom % 4 != 0) begin
               case (sel)
                  0, 1:    set_req(r, 4'd1, 4'($urandom), 4'($urandom));
                  2, 3:    set_req(r, 4'd2, 4'($urandom), 4'($urandom));
                  4, 5:    set_req(r, 4'd3, 4'($urandom), 4'($urandom));
                  6:       set_req(r, 4'($urandom_range(4, 15)), 4'($urandom), 4'($urandom));
                  default: set_req(r, 4'd3, 4'($urandom), 4'($urandom_range(0, 2)));
               endcase
            end
         end
         if (!pv[0] && !pv[1]) set_req(0, 4'd1, 4'($urandom), 4'($urandom));
         serve_all(($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      // Abort a MUL at its third issue (count = 3) with an asynchronous reset.
      set_req(1, 4'd3, 4'd3, 4'd5);
      apply();
      #1;
      check("abort_ready", req1_ready, 1);
      @(posedge clock);
      @(negedge clock);
      pv[1] = 1'b0;
      pulses = 0; k = 0;
      while (k < 40) begin
         if (alu_opcode == 4'd1) pulses++;
         apply();
         if (pulses == 3) break;
         @(negedge clock);
         k++;
      end
      check("abort_third_ain", alu_ain, 6);
      reset = 1'b1;
      #1;
      check("abort_alu",  {alu_opcode, alu_ain, alu_bin}, 0);
      check("abort_resp", {resp_valid, resp_id, resp_err, resp_data}, 0);
      check("abort_busy", busy, 0);
      check("abort_rdy",  {req0_ready, req1_ready}, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      lg_m  = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("abort_no_resp", resp_valid, 0);
      end
      set_req(0, 4'd1, 4'd6, 4'd7);
      set_req(1, 4'd3, 4'd5, 4'd2);
      serve_all(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
